decode_stage: RTL and testbench

Second stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. Consumes the IF/ID outputs (PC1, Instr1), holds the 32×32 general register file written back by the WB stage, and resolves all control flow in ID. It returns the next-PC select and targets to fetch, and registers the decoded operands into the ID/EX pipeline register.

---
 rtl/decode_stage.sv | 153 +++++++++++++++
 tb/tb_decode_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Pipeline ID stage: decode, register file with WB bypass, branch/jump resolution, ID/EX register.
// Latency: targets and PCSel are combinational; ID/EX outputs appear one clock after the inputs.
// No backpressure: a stalled ID is turned into a bubble by the hazard unit through ID_EX_Clr.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC1,
    input  logic [31:0] Instr1,
    input  logic        WB_We,
    input  logic [4:0]  WB_A3,
    input  logic [31:0] WB_WD,
    input  logic        FwdRS_M,
    input  logic        FwdRT_M,
    input  logic [31:0] M_Data,
    input  logic        ID_EX_Clr,
    output logic [1:0]  PCSel,
    output logic [31:0] PC_beq,
    output logic [31:0] PC_j,
    output logic [31:0] PC_jr,
    output logic [31:0] PC2,
    output logic [31:0] Instr2,
    output logic [31:0] RS2,
    output logic [31:0] RT2,
    output logic [31:0] EXT2,
    output logic [4:0]  A3_2
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_JR    = 6'b001000;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;

    assign op       = Instr1[31:26];
    assign rs       = Instr1[25:21];
    assign rt       = Instr1[20:16];
    assign rd       = Instr1[15:11];
    assign funct    = Instr1[5:0];
    assign imm      = Instr1[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;

    assign is_addu = (op == OP_R) && (funct == F_ADDU);
    assign is_subu = (op == OP_R) && (funct == F_SUBU);
    assign is_jr   = (op == OP_R) && (funct == F_JR);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_lui  = (op == OP_LUI);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);

    // $0 is never written, so after reset it always reads as zero.
    logic [31:0] regs [32];

    // Register file write from WB; a reset clears every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_We && (WB_A3 != 5'd0)) begin
            regs[WB_A3] <= WB_WD;
        end
    end

    logic [31:0] rs_raw, rt_raw, rs_v, rt_v;

    // Same-cycle WB bypass, then M-stage forwarding takes precedence over it.
    assign rs_raw = (WB_We && (WB_A3 == rs) && (rs != 5'd0)) ? WB_WD : regs[rs];
    assign rt_raw = (WB_We && (WB_A3 == rt) && (rt != 5'd0)) ? WB_WD : regs[rt];
    assign rs_v   = FwdRS_M ? M_Data : rs_raw;
    assign rt_v   = FwdRT_M ? M_Data : rt_raw;

    // Targets are always driven; PCSel decides which one fetch uses.
    assign PC_beq = PC1 + 32'd4 + {imm_sext[29:0], 2'b00};
    assign PC_j   = {PC1[31:28], Instr1[25:0], 2'b00};
    assign PC_jr  = rs_v;

    logic [31:0] ext;
    logic [4:0]  a3;

    // Decode immediate extension, destination register and next-PC select.
    always_comb begin
        ext   = '0;
        a3    = '0;
        PCSel = 2'b00;
        if (is_ori) begin
            ext = {16'h0000, imm};
        end else if (is_lui) begin
            ext = {imm, 16'h0000};
        end else if (is_lw || is_sw || is_beq) begin
            ext = imm_sext;
        end
        if (is_addu || is_subu) begin
            a3 = rd;
        end else if (is_ori || is_lui || is_lw) begin
            a3 = rt;
        end else if (is_jal) begin
            a3 = 5'd31;
        end
        if (is_beq && (rs_v == rt_v)) begin
            PCSel = 2'b01;
        end else if (is_j || is_jal) begin
            PCSel = 2'b10;
        end else if (is_jr) begin
            PCSel = 2'b11;
        end
    end

    // ID/EX pipeline register: reset beats bubble insertion, which beats load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC2    <= '0;
            Instr2 <= '0;
            RS2    <= '0;
            RT2    <= '0;
            EXT2   <= '0;
            A3_2   <= '0;
        end else if (ID_EX_Clr) begin
            PC2    <= '0;
            Instr2 <= '0;
            RS2    <= '0;
            RT2    <= '0;
            EXT2   <= '0;
            A3_2   <= '0;
        end else begin
            PC2    <= PC1;
            Instr2 <= Instr1;
            RS2    <= rs_v;
            RT2    <= rt_v;
            EXT2   <= ext;
            A3_2   <= a3;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus queues expectations, monitors compare.
// Combinational results are checked at the falling edge, ID/EX results 1 ns after the rising edge.
// Inputs change 2 ns after each rising edge.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] PC1, Instr1, WB_WD, M_Data;
    logic        WB_We, FwdRS_M, FwdRT_M, ID_EX_Clr;
    logic [4:0]  WB_A3;
    logic [1:0]  PCSel;
    logic [31:0] PC_beq, PC_j, PC_jr, PC2, Instr2, RS2, RT2, EXT2;
    logic [4:0]  A3_2;

    decode_stage dut (
        .clk(clk), .reset(reset), .PC1(PC1), .Instr1(Instr1),
        .WB_We(WB_We), .WB_A3(WB_A3), .WB_WD(WB_WD),
        .FwdRS_M(FwdRS_M), .FwdRT_M(FwdRT_M), .M_Data(M_Data), .ID_EX_Clr(ID_EX_Clr),
        .PCSel(PCSel), .PC_beq(PC_beq), .PC_j(PC_j), .PC_jr(PC_jr),
        .PC2(PC2), .Instr2(Instr2), .RS2(RS2), .RT2(RT2), .EXT2(EXT2), .A3_2(A3_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [3:0]  m;      // [3] PCSel [2] PC_beq [1] PC_j [0] PC_jr
        logic [1:0]  sel;
        logic [31:0] beq, j, jr;
    } comb_t;

    typedef struct {
        int          id;
        logic [31:0] pc, instr, rs, rt, ext;
        logic [4:0]  a3;
    } pipe_t;

    comb_t cq[$];
    pipe_t pq[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int s, input int t, input int d, input logic [5:0] f);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input int s, input int t, input logic [15:0] i);
        return {o, 5'(s), 5'(t), i};
    endfunction

    // Combinational monitor.
    always @(negedge clk) begin
        comb_t c;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            if (c.m[3]) chk("PCSel",  c.id, {30'd0, PCSel}, {30'd0, c.sel});
            if (c.m[2]) chk("PC_beq", c.id, PC_beq, c.beq);
            if (c.m[1]) chk("PC_j",   c.id, PC_j,   c.j);
            if (c.m[0]) chk("PC_jr",  c.id, PC_jr,  c.jr);
        end
    end

    // ID/EX monitor.
    always @(posedge clk) begin
        pipe_t p;
        #1;
        if (pq.size() > 0) begin
            p = pq.pop_front();
            chk("PC2",    p.id, PC2,    p.pc);
            chk("Instr2", p.id, Instr2, p.instr);
            chk("RS2",    p.id, RS2,    p.rs);
            chk("RT2",    p.id, RT2,    p.rt);
            chk("EXT2",   p.id, EXT2,   p.ext);
            chk("A3_2",   p.id, {27'd0, A3_2}, {27'd0, p.a3});
        end
    end

    task automatic idle();
        PC1 = 32'h3000; Instr1 = 32'h0;
        WB_We = 1'b0; WB_A3 = 5'd0; WB_WD = 32'h0;
        FwdRS_M = 1'b0; FwdRT_M = 1'b0; M_Data = 32'h0; ID_EX_Clr = 1'b0;
    endtask

    task automatic go(input int id, input logic [3:0] m, input logic [1:0] sel,
                      input logic [31:0] beq, input logic [31:0] j, input logic [31:0] jr,
                      input logic [31:0] epc, input logic [31:0] einstr, input logic [31:0] ers,
                      input logic [31:0] ert, input logic [31:0] eext, input logic [4:0] ea3);
        comb_t c;
        pipe_t p;
        c.id = id; c.m = m; c.sel = sel; c.beq = beq; c.j = j; c.jr = jr;
        p.id = id; p.pc = epc; p.instr = einstr; p.rs = ers; p.rt = ert; p.ext = eext; p.a3 = ea3;
        cq.push_back(c);
        pq.push_back(p);
        @(posedge clk);
        #2;
    endtask

    logic [31:0] ins;

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // 1: write $5 and read it in the same cycle via bypass
        idle(); WB_We = 1; WB_A3 = 5; WB_WD = 32'h1234; ins = rtype(5, 0, 3, 6'h21); Instr1 = ins;
        go(1, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 32'h1234, 0, 0, 5'd3);
        // 2: write to $0 is discarded, $5 now from the array
        idle(); WB_We = 1; WB_A3 = 0; WB_WD = 32'hDEAD; ins = rtype(0, 5, 3, 6'h21); Instr1 = ins;
        go(2, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 32'h1234, 0, 5'd3);
        // 3: $0 still reads zero; write $1=7
        idle(); WB_We = 1; WB_A3 = 1; WB_WD = 32'd7; ins = rtype(0, 0, 8, 6'h21); Instr1 = ins;
        go(3, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 0, 0, 5'd8);
        // 4: beq $1,$2,-2 taken ($2=7 bypassed)
        idle(); PC1 = 32'h3010; WB_We = 1; WB_A3 = 2; WB_WD = 32'd7; ins = itype(6'h04, 1, 2, 16'hFFFE); Instr1 = ins;
        go(4, 4'b1100, 2'b01, 32'h300C, 0, 0, 32'h3010, ins, 32'd7, 32'd7, 32'hFFFFFFFE, 5'd0);
        // 5: beq not taken ($2=8)
        idle(); PC1 = 32'h3010; WB_We = 1; WB_A3 = 2; WB_WD = 32'd8; Instr1 = ins;
        go(5, 4'b1100, 2'b00, 32'h300C, 0, 0, 32'h3010, ins, 32'd7, 32'd8, 32'hFFFFFFFE, 5'd0);
        // 6: jal 0x0C01
        idle(); ins = 32'h0C000C01; Instr1 = ins;
        go(6, 4'b1010, 2'b10, 0, 32'h3004, 0, 32'h3000, ins, 0, 0, 0, 5'd31);
        // 7: jr $31 with M forwarding
        idle(); FwdRS_M = 1; M_Data = 32'h3008; ins = rtype(31, 0, 0, 6'h08); Instr1 = ins;
        go(7, 4'b1001, 2'b11, 0, 0, 32'h3008, 32'h3000, ins, 32'h3008, 0, 0, 5'd0);
        // 8: WB bypass and M forward on rs together: M wins; rt keeps WB value
        idle(); WB_We = 1; WB_A3 = 6; WB_WD = 32'h55; FwdRS_M = 1; M_Data = 32'hABCD; ins = rtype(6, 6, 7, 6'h21); Instr1 = ins;
        go(8, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 32'hABCD, 32'h55, 0, 5'd7);
        // 9: ori $4,$0,0xFFFF
        idle(); ins = itype(6'h0D, 0, 4, 16'hFFFF); Instr1 = ins;
        go(9, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 0, 32'h0000FFFF, 5'd4);
        // 10: lw $4,-4($29)
        idle(); ins = itype(6'h23, 29, 4, 16'hFFFC); Instr1 = ins;
        go(10, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 0, 32'hFFFFFFFC, 5'd4);
        // 11: lui $4,0x8000
        idle(); ins = itype(6'h0F, 0, 4, 16'h8000); Instr1 = ins;
        go(11, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 0, 32'h80000000, 5'd4);
        // 12: sw $5,8($0) writes no register
        idle(); ins = itype(6'h2B, 0, 5, 16'h0008); Instr1 = ins;
        go(12, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 32'h1234, 32'h8, 5'd0);
        // 13: j 0x100 keeps upper PC nibble
        idle(); PC1 = 32'hA0000000; ins = 32'h08000100; Instr1 = ins;
        go(13, 4'b1010, 2'b10, 0, 32'hA0000400, 0, 32'hA0000000, ins, 0, 0, 0, 5'd0);
        // 14: unknown opcode is a nop
        idle(); ins = 32'hFC000000; Instr1 = ins;
        go(14, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 0, 0, 5'd0);
        // 15: add (funct 100000) is not decoded
        idle(); ins = rtype(5, 0, 3, 6'h20); Instr1 = ins;
        go(15, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 32'h1234, 0, 0, 5'd0);
        // 16: bubble over a valid addu
        idle(); ID_EX_Clr = 1; ins = rtype(5, 0, 3, 6'h21); Instr1 = ins;
        go(16, 4'b1000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        // 17: load a valid addu so the async reset has something to clear
        idle(); ins = rtype(5, 5, 3, 6'h21); Instr1 = ins;
        go(17, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 32'h1234, 32'h1234, 0, 5'd3);

        // Reset and bubble together between edges: outputs clear at once
        reset = 1'b1; ID_EX_Clr = 1'b1;
        #1;
        chk("async_rst_PC2",    18, PC2,    0);
        chk("async_rst_Instr2", 18, Instr2, 0);
        chk("async_rst_RS2",    18, RS2,    0);
        chk("async_rst_A3_2",   18, {27'd0, A3_2}, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_RT2", 18, RT2, 0);
        #1;
        reset = 1'b0;

        // 19: register file was cleared by reset
        idle(); ins = rtype(5, 6, 3, 6'h21); Instr1 = ins;
        go(19, 4'b1000, 2'b00, 0, 0, 0, 32'h3000, ins, 0, 0, 0, 5'd3);

        idle();
        @(posedge clk);
        #3;
        chk("leftover", 0, 32'(cq.size() + pq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
